// File: rtl/lsu_dmem_master.sv
// RV32I load/store initiator for a word-organised data memory; sub-word stores use read-modify-write.
// Optional LSU_RANGE_CHECK_EN: addresses above the memory range are rejected instead of aliasing.
module lsu_dmem_master #(
    parameter int unsigned ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [2:0]            req_funct3,
    input  logic [31:0]           req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  resp_valid,
    output logic [31:0]           resp_rdata,
    output logic                  resp_err,
    output logic                  mem_wr_en,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    input  logic [31:0]           mem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_MERGE,
        S_RESP
    } state_t;

    state_t                r_state;
    logic                  r_we;
    logic [2:0]            r_funct3;
    logic [ADDR_WIDTH+1:0] r_addr;
    logic [31:0]           r_wdata;
    logic [31:0]           r_merge;
    logic                  r_resp_valid;
    logic [31:0]           r_resp_rdata;
    logic                  r_resp_err;

    logic                  w_req_err;
    logic                  w_sub_store;
    logic [4:0]            w_lane_shift;
    logic [31:0]           w_rshift;
    logic [31:0]           w_load_data;
    logic [31:0]           w_lane_mask;
    logic [31:0]           w_lane_data;
    logic [31:0]           w_merge_data;
    logic                  w_rd_en;
    logic                  w_wr_en;

`ifndef LSU_RANGE_CHECK_EN
    logic                  w_unused_addr;
    assign w_unused_addr = &{1'b0, req_addr[31:ADDR_WIDTH+2]};
`endif

    // Request legality is decided from the live inputs so an error can go straight to RESP.
    always_comb begin
        w_req_err = 1'b0;
        case (req_funct3)
            3'b000:  w_req_err = 1'b0;
            3'b001:  w_req_err = req_addr[0];
            3'b010:  w_req_err = |req_addr[1:0];
            3'b100:  w_req_err = req_we;
            3'b101:  w_req_err = req_we | req_addr[0];
            default: w_req_err = 1'b1;
        endcase
`ifdef LSU_RANGE_CHECK_EN
        w_req_err = w_req_err | (|req_addr[31:ADDR_WIDTH+2]);
`endif
    end

    assign w_sub_store  = r_we & (r_funct3[1:0] != 2'b10);
    assign w_lane_shift = {r_addr[1:0], 3'b000};
    assign w_rshift     = mem_rdata >> w_lane_shift;

    always_comb begin
        case (r_funct3)
            3'b000:  w_load_data = {{24{w_rshift[7]}}, w_rshift[7:0]};
            3'b001:  w_load_data = {{16{w_rshift[15]}}, w_rshift[15:0]};
            3'b100:  w_load_data = {24'h0, w_rshift[7:0]};
            3'b101:  w_load_data = {16'h0, w_rshift[15:0]};
            default: w_load_data = mem_rdata;
        endcase
    end

    always_comb begin
        if (r_funct3[0]) begin
            w_lane_mask = 32'h0000_FFFF << w_lane_shift;
            w_lane_data = {16'h0, r_wdata[15:0]} << w_lane_shift;
        end else begin
            w_lane_mask = 32'h0000_00FF << w_lane_shift;
            w_lane_data = {24'h0, r_wdata[7:0]} << w_lane_shift;
        end
        w_merge_data = (r_merge & ~w_lane_mask) | (w_lane_data & w_lane_mask);
    end

    // Memory strobes decode from the state register so reset removes them immediately.
    assign w_rd_en = (r_state == S_EXEC) & (~r_we | w_sub_store);
    assign w_wr_en = ((r_state == S_EXEC) & r_we & ~w_sub_store) | (r_state == S_MERGE);

    assign mem_rd_en = w_rd_en;
    assign mem_wr_en = w_wr_en;
    assign mem_addr  = (w_rd_en | w_wr_en) ? r_addr[ADDR_WIDTH+1:2] : '0;
    assign mem_wdata = (r_state == S_MERGE)              ? w_merge_data :
                       ((r_state == S_EXEC) & w_wr_en)   ? r_wdata      : '0;

    assign req_ready  = (r_state == S_IDLE);
    assign resp_valid = r_resp_valid;
    assign resp_rdata = r_resp_rdata;
    assign resp_err   = r_resp_err;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_we         <= 1'b0;
            r_funct3     <= '0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_merge      <= '0;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= '0;
            r_resp_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_we     <= req_we;
                        r_funct3 <= req_funct3;
                        r_addr   <= req_addr[ADDR_WIDTH+1:0];
                        r_wdata  <= req_wdata;
                        if (w_req_err) begin
                            r_resp_valid <= 1'b1;
                            r_resp_err   <= 1'b1;
                            r_resp_rdata <= '0;
                            r_state      <= S_RESP;
                        end else begin
                            r_state <= S_EXEC;
                        end
                    end
                end
                S_EXEC: begin
                    if (w_sub_store) begin
                        r_merge <= mem_rdata;
                        r_state <= S_MERGE;
                    end else begin
                        r_resp_valid <= 1'b1;
                        r_resp_err   <= 1'b0;
                        r_resp_rdata <= r_we ? '0 : w_load_data;
                        r_state      <= S_RESP;
                    end
                end
                S_MERGE: begin
                    r_resp_valid <= 1'b1;
                    r_resp_err   <= 1'b0;
                    r_resp_rdata <= '0;
                    r_state      <= S_RESP;
                end
                S_RESP: begin
                    r_resp_valid <= 1'b0;
                    r_state      <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_dmem_master.sv
// Bench for lsu_dmem_master: directed vector table, reset-abort sequence, randomized requests vs. a reference model.
module tb_lsu_dmem_master;

    localparam int unsigned AW    = 12;
    localparam int unsigned DEPTH = 4096;

    logic          clk = 1'b0;
    logic          reset;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [2:0]    req_funct3;
    logic [31:0]   req_addr;
    logic [31:0]   req_wdata;
    logic          resp_valid;
    logic [31:0]   resp_rdata;
    logic          resp_err;
    logic          mem_wr_en;
    logic          mem_rd_en;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;

    always #5 clk = ~clk;

    lsu_dmem_master #(.ADDR_WIDTH(AW)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_wr_en  (mem_wr_en),
        .mem_rd_en  (mem_rd_en),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    logic [31:0] mem     [0:DEPTH-1];
    logic [31:0] ref_mem [0:DEPTH-1];

    function automatic logic [31:0] init_word(input int unsigned i);
        return 32'h9E37_79B9 * (i + 1);
    endfunction

    assign mem_rdata = mem[mem_addr];

    initial begin
        for (int unsigned i = 0; i < DEPTH; i++) mem[i] = init_word(i);
        forever begin
            @(posedge clk);
            if (mem_wr_en) mem[mem_addr] <= mem_wdata;
        end
    end

    int nvec = 0;
    int nmis = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: byte-addressed RV32I semantics over a word array.
    task automatic model(input bit we, input bit [2:0] f3, input bit [31:0] addr, input bit [31:0] wdata,
                         output bit [31:0] rdata, output bit err, output int lat,
                         output int nrd, output int nwr);
        int unsigned idx  = (addr >> 2) % DEPTH;
        int unsigned off  = addr % 4;
        int unsigned size;
        bit          legal;
        bit [31:0]   w, v, mask;
        case (f3)
            3'd0, 3'd4: size = 1;
            3'd1, 3'd5: size = 2;
            3'd2:       size = 4;
            default:    size = 0;
        endcase
        legal = (size != 0);
        if (legal && we && f3 >= 3'd4) legal = 0;
        if (legal && (off % size) != 0) legal = 0;
`ifdef LSU_RANGE_CHECK_EN
        if (addr >= (32'd1 << (AW + 2))) legal = 0;
`endif
        rdata = 0; err = !legal; nrd = 0; nwr = 0; lat = 1;
        if (legal && !we) begin
            w = ref_mem[idx];
            v = w >> (8 * off);
            if (size == 1) begin
                v = v & 32'hFF;
                if (f3 == 3'd0 && v >= 32'h80) v = v | 32'hFFFF_FF00;
            end else if (size == 2) begin
                v = v & 32'hFFFF;
                if (f3 == 3'd1 && v >= 32'h8000) v = v | 32'hFFFF_0000;
            end
            rdata = v; lat = 2; nrd = 1;
        end else if (legal) begin
            if (size == 4)      mask = 32'hFFFF_FFFF;
            else if (size == 2) mask = 32'hFFFF << (8 * off);
            else                mask = 32'hFF << (8 * off);
            ref_mem[idx] = (ref_mem[idx] & ~mask) | ((wdata << (8 * off)) & mask);
            lat = (size == 4) ? 2 : 3;
            nrd = (size == 4) ? 0 : 1;
            nwr = 1;
        end
    endtask

    task automatic run_req(input string tag, input bit we, input bit [2:0] f3, input bit [31:0] addr,
                           input bit [31:0] wdata, input bit [31:0] e_rdata, input bit e_err,
                           input int e_lat, input int e_rd, input int e_wr);
        int          lat = 0;
        int          nrd = 0;
        int          nwr = 0;
        int          bad = 0;
        logic [31:0] rd  = 0;
        logic        er  = 0;
        bit [AW-1:0] waddr = addr[AW+1:2];
        check({tag, " ready_at_issue"}, req_ready, 1);
        req_valid = 1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
        @(posedge clk); #1;
        req_valid = 0; req_we = 1'($urandom); req_funct3 = 3'($urandom);
        req_addr = $urandom; req_wdata = $urandom;
        for (int k = 1; k <= 8; k++) begin
            if (mem_rd_en) nrd++;
            if (mem_wr_en) nwr++;
            if (mem_rd_en && mem_wr_en) bad++;
            if ((mem_rd_en || mem_wr_en) && mem_addr !== waddr) bad++;
            if (!(mem_rd_en || mem_wr_en) && (mem_addr !== '0 || mem_wdata !== '0)) bad++;
            if (req_ready) bad++;
            if (resp_valid) begin
                lat = k; rd = resp_rdata; er = resp_err;
                break;
            end
            @(posedge clk); #1;
        end
        check({tag, " latency"}, lat, e_lat);
        check({tag, " rdata"}, rd, e_rdata);
        check({tag, " err"}, er, e_err);
        check({tag, " rd_cycles"}, nrd, e_rd);
        check({tag, " wr_cycles"}, nwr, e_wr);
        check({tag, " bus_rules"}, bad, 0);
        @(posedge clk); #1;
        check({tag, " pulse_end"}, resp_valid, 0);
        check({tag, " ready_after"}, req_ready, 1);
        check({tag, " rdata_hold"}, resp_rdata, e_rdata);
    endtask

    typedef struct {
        bit        we;
        bit [2:0]  f3;
        bit [31:0] addr;
        bit [31:0] wdata;
        bit [31:0] rdata;
        bit        err;
        int        lat;
    } vec_t;

    vec_t tbl[$];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit [31:0] m_rdata;
        bit        m_err;
        int        m_lat, m_rd, m_wr;
        int        seen;

        for (int unsigned i = 0; i < DEPTH; i++) ref_mem[i] = init_word(i);
        reset = 1; req_valid = 0; req_we = 0; req_funct3 = 0; req_addr = 0; req_wdata = 0;

`ifdef LSU_RANGE_CHECK_EN
        tbl.push_back('{0, 3'd2, 32'h0000_4000, 32'h0, 32'h0, 1, 1});
`else
        tbl.push_back('{0, 3'd2, 32'h0000_4000, 32'h0, init_word(0), 0, 2});
`endif
        tbl.push_back('{1, 3'd2, 32'h10, 32'hDEAD_BEEF, 32'h0,         0, 2});
        tbl.push_back('{0, 3'd2, 32'h10, 32'h0,         32'hDEAD_BEEF, 0, 2});
        tbl.push_back('{1, 3'd0, 32'h12, 32'h0000_0055, 32'h0,         0, 3});
        tbl.push_back('{0, 3'd2, 32'h10, 32'h0,         32'hDE55_BEEF, 0, 2});
        tbl.push_back('{0, 3'd0, 32'h13, 32'h0,         32'hFFFF_FFDE, 0, 2});
        tbl.push_back('{0, 3'd4, 32'h13, 32'h0,         32'h0000_00DE, 0, 2});
        tbl.push_back('{0, 3'd1, 32'h10, 32'h0,         32'hFFFF_BEEF, 0, 2});
        tbl.push_back('{0, 3'd5, 32'h12, 32'h0,         32'h0000_DE55, 0, 2});
        tbl.push_back('{0, 3'd2, 32'h11, 32'h0,         32'h0,         1, 1});
        tbl.push_back('{1, 3'd1, 32'h13, 32'h1234_5678, 32'h0,         1, 1});
        tbl.push_back('{0, 3'd3, 32'h10, 32'h0,         32'h0,         1, 1});
        tbl.push_back('{1, 3'd4, 32'h10, 32'hFFFF_FFFF, 32'h0,         1, 1});
        tbl.push_back('{1, 3'd7, 32'h10, 32'hFFFF_FFFF, 32'h0,         1, 1});
        tbl.push_back('{1, 3'd1, 32'h10, 32'hFFFF_7A11, 32'h0,         0, 3});
        tbl.push_back('{0, 3'd2, 32'h10, 32'h0,         32'hDE55_7A11, 0, 2});
        tbl.push_back('{0, 3'd1, 32'h12, 32'h0,         32'hFFFF_DE55, 0, 2});
        tbl.push_back('{0, 3'd0, 32'h11, 32'h0,         32'h0000_007A, 0, 2});
        tbl.push_back('{0, 3'd1, 32'h10, 32'h0,         32'h0000_7A11, 0, 2});
        tbl.push_back('{1, 3'd0, 32'h13, 32'h0000_0001, 32'h0,         0, 3});
        tbl.push_back('{0, 3'd2, 32'h10, 32'h0,         32'h0155_7A11, 0, 2});
        tbl.push_back('{0, 3'd4, 32'h10, 32'h0,         32'h0000_0011, 0, 2});

        @(posedge clk); @(posedge clk); #1;
        check("rst req_ready", req_ready, 1);
        check("rst resp_valid", resp_valid, 0);
        check("rst resp_rdata", resp_rdata, 0);
        check("rst resp_err", resp_err, 0);
        check("rst mem_rd_en", mem_rd_en, 0);
        check("rst mem_wr_en", mem_wr_en, 0);
        check("rst mem_addr", mem_addr, 0);
        check("rst mem_wdata", mem_wdata, 0);
        reset = 0;
        @(posedge clk); #1;

        foreach (tbl[i]) begin
            model(tbl[i].we, tbl[i].f3, tbl[i].addr, tbl[i].wdata, m_rdata, m_err, m_lat, m_rd, m_wr);
            run_req($sformatf("vec%0d", i), tbl[i].we, tbl[i].f3, tbl[i].addr, tbl[i].wdata,
                    tbl[i].rdata, tbl[i].err, tbl[i].lat, m_rd, m_wr);
        end
        check("tbl word4", mem[4], 32'h0155_7A11);

        // Reset while an SB sits in MERGE: the write must never land.
        req_valid = 1; req_we = 1; req_funct3 = 3'd0; req_addr = 32'h10; req_wdata = 32'hEE;
        @(posedge clk); #1;
        req_valid = 0;
        check("abort exec rd_en", mem_rd_en, 1);
        @(posedge clk); #1;
        check("abort merge wr_en", mem_wr_en, 1);
        reset = 1; #1;
        check("abort wr_en drop", mem_wr_en, 0);
        check("abort rd_en drop", mem_rd_en, 0);
        check("abort mem_addr", mem_addr, 0);
        check("abort req_ready", req_ready, 1);
        check("abort resp_valid", resp_valid, 0);
        @(posedge clk); #1;
        reset = 0;
        seen = 0;
        for (int k = 0; k < 3; k++) begin
            if (resp_valid || mem_wr_en || mem_rd_en) seen++;
            @(posedge clk); #1;
        end
        check("abort quiet", seen, 0);
        check("abort word4", mem[4], 32'h0155_7A11);
        run_req("abort LW", 0, 3'd2, 32'h10, 32'h0, 32'h0155_7A11, 0, 2, 1, 0);

        for (int n = 0; n < 300; n++) begin
            bit        we    = 1'($urandom);
            bit [2:0]  f3    = 3'($urandom);
            bit [31:0] upper = ($urandom % 4 == 0) ? $urandom : 32'h0;
            bit [31:0] addr  = (upper << (AW + 2)) | (($urandom % 16) << 2) | ($urandom % 4);
            bit [31:0] wdata = $urandom;
            int unsigned idx = (addr >> 2) % DEPTH;
            model(we, f3, addr, wdata, m_rdata, m_err, m_lat, m_rd, m_wr);
            run_req($sformatf("rnd%0d", n), we, f3, addr, wdata, m_rdata, m_err, m_lat, m_rd, m_wr);
            check($sformatf("rnd%0d mem_word", n), mem[idx], ref_mem[idx]);
            repeat ($urandom % 3) @(posedge clk);
            #1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
